dllp_tx_scheduler: RTL and testbench
====================================

Name: dllp_tx_scheduler

Overview:
Owns the RC Data Link Layer transmit slot toward the PIPE framer: exactly one DLLP or one TLP beat per pclk. Sequences the DL control state machine (Inactive -> InitFC1 -> InitFC2 -> Active). In Active it arbitrates Ack/Nak, UpdateFC and TLP traffic. Sits between the retry buffer/TLP source, the Ack/Nak generator, the FC credit tracker and the framer/LCRC stage.

Parameters:
UPDFC_PERIOD, 1024, cycles between forced UpdateFC rounds in Active (>=16)
INITFC_GAP, 8, idle cycles between InitFC triples
MAX_DLLP_BURST, 4, consecutive DLLPs allowed while a TLP is waiting before one TLP is forced

Ports:
pclk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
link_up_i  in  1  physical link up (LTSSM L0)
rx_fc1_i  in  3  pulse per type {Cpl,NP,P}: InitFC1 or InitFC2 received
rx_fc2_i  in  1  pulse: InitFC2, UpdateFC or TLP received
fc_hdr_i  in  24  advertised header credits, 8b per type {Cpl,NP,P}
fc_data_i  in  36  advertised data credits, 12b per type
updfc_req_i  in  3  level per type: credit release needs UpdateFC
ack_req_i  in  1  level: Ack/Nak pending
ack_nak_i  in  1  1=Nak, 0=Ack
ack_seq_i  in  12  AckNak_Seq_Num
ack_done_o  out  1  pulse: Ack/Nak sent
updfc_done_o  out  3  pulse per type: UpdateFC sent
tlp_req_i  in  1  TLP beat available
tlp_last_i  in  1  current beat is last of TLP
tlp_gnt_o  out  1  TLP beat consumed this cycle
dllp_valid_o  out  1  dllp_o valid this cycle
dllp_o  out  32  DLLP body before CRC16
dl_state_o  out  2  0 Inactive, 1 InitFC1, 2 InitFC2, 3 Active
dl_up_o  out  1  state==Active
stat_ack_o, stat_nak_o, stat_updfc_o  out  16 each  statistics counters

Behaviour:
- Reset (rst_n=1): all outputs 0, state Inactive, flags/pending/timers cleared. Outputs registered; decision at edge N visible at N+1.
- dllp_valid_o and tlp_gnt_o never both 1.
- DLLP format: [31:24] type, [23:22] HdrScale=0, [21:14] HdrFC, [13:12] DataScale=0, [11:0] DataFC. Types: InitFC1 P/NP/Cpl 0x40/0x50/0x60; InitFC2 0xC0/0xD0/0xE0; UpdateFC 0x80/0x90/0xA0. Ack 0x00, Nak 0x10; [23:12]=0, [11:0]=ack_seq_i sampled in send cycle.
- Inactive: tlp_gnt_o=0. link_up_i=1 -> InitFC1.
- InitFC1: send triple P,NP,Cpl on consecutive cycles, then INITFC_GAP idle, repeat. FL1 flag per type set by rx_fc1_i. All three set AND triple complete -> InitFC2.
- InitFC2: same cadence with InitFC2 types. rx_fc2_i sets FI2 (sticky, also settable in InitFC1). FI2 AND triple complete -> Active.
- Triple never split: state changes only after its Cpl DLLP.
- Active priority: Ack/Nak > UpdateFC > TLP. UpdateFC pending per type = updfc_req_i | timer round; service order P, NP, Cpl.
- Timer counts in Active; reaching UPDFC_PERIOD-1 sets all three pending, reloads 0.
- TLP non-preemptive: after grant of first beat, tlp_gnt_o follows tlp_req_i until beat with tlp_last_i; DLLPs wait. tlp_req_i low mid-TLP = idle slot, TLP still owns slot.
- Starvation: MAX_DLLP_BURST consecutive DLLPs with tlp_req_i high and no TLP open -> next free slot goes to TLP.
- ack_done_o/updfc_done_o pulse in cycle DLLP is presented; requester drops level by next cycle. Same-cycle new request honored next arbitration.
- link_up_i=0 in any state: next cycle Inactive, flags/pending/burst/timer cleared, open TLP abandoned (tlp_gnt_o=0), no done pulses.
- Ack/Nak/UpdateFC requests outside Active held, not serviced.

Optional Feature:
DLLP_TX_STATS_EN: defined -> stat_* count Ack, Nak, UpdateFC DLLPs sent, 16b saturating at 0xFFFF, cleared by reset and on entry to Inactive. Undefined -> stat_* tied 0, no counter logic.

Test Plan:
- Reset, link_up_i=1, no rx -> repeating 0x40,0x50,0x60 then 8 idle; dl_state_o=1 indefinitely.
- rx_fc1_i=3'b111 mid-triple, then rx_fc2_i -> triple completes, InitFC2 0xC0/0xD0/0xE0, then dl_up_o=1 after Cpl DLLP.
- Active, ack_req_i=1 ack_nak_i=1 seq 0x123 with updfc_req_i=3'b001 and tlp_req_i same cycle -> dllp_o=0x10000123, then 0x80 UpdateFC with fc_hdr_i/fc_data_i P fields, then TLP.
- 5-beat TLP granted, ack_req_i raised on beat 2 -> all 5 beats granted contiguously, Ack on next slot.
- Continuous updfc_req_i=3'b111 and ack requests with tlp_req_i high -> TLP beat after every 4 DLLPs; with UPDFC_PERIOD=16 idle -> UpdateFC triple every 16 cycles.
- link_up_i dropped mid-TLP -> next cycle tlp_gnt_o=0, dl_state_o=0; with DLLP_TX_STATS_EN counters read 0.

Source files
------------

// File: rtl/dllp_tx_scheduler.sv
// dllp_tx_scheduler
// -----------------------------------------------------------------------------
// Owns the Data Link Layer transmit slot toward the PIPE framer. Each pclk
// carries at most one DLLP or one TLP beat. Sequences the DL control state
// (Inactive -> InitFC1 -> InitFC2 -> Active). In Active it arbitrates
// Ack/Nak > UpdateFC > TLP, with a starvation guard for waiting TLPs.
//
// Reset: rst_n is asynchronous and ACTIVE-HIGH (rst_n = 1 holds reset).
// Every output is registered: a decision taken before edge N shows after N.
//
// Optional build macro: DLLP_TX_STATS_EN enables saturating 16-bit Ack, Nak
// and UpdateFC counters on stat_*_o. Without it those outputs are tied to 0.
//
// Ports
//   pclk, rst_n          clock, reset
//   link_up_i            physical link in L0
//   rx_fc1_i[2:0]        {Cpl,NP,P} InitFC1/InitFC2 received pulses
//   rx_fc2_i             InitFC2/UpdateFC/TLP received pulse
//   fc_hdr_i, fc_data_i  advertised credits, {Cpl,NP,P} packed
//   updfc_req_i[2:0]     per-type UpdateFC request levels
//   ack_req_i/ack_nak_i/ack_seq_i   Ack/Nak request, type, sequence
//   ack_done_o, updfc_done_o        pulse in the cycle the DLLP is presented
//   tlp_req_i, tlp_last_i, tlp_gnt_o   TLP beat handshake
//   dllp_valid_o, dllp_o  DLLP body (pre-CRC16)
//   dl_state_o, dl_up_o   DL control state
//   stat_ack_o, stat_nak_o, stat_updfc_o   statistics
// -----------------------------------------------------------------------------
module dllp_tx_scheduler #(
  parameter int UPDFC_PERIOD   = 1024,
  parameter int INITFC_GAP     = 8,
  parameter int MAX_DLLP_BURST = 4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        link_up_i,
  input  logic [2:0]  rx_fc1_i,
  input  logic        rx_fc2_i,
  input  logic [23:0] fc_hdr_i,
  input  logic [35:0] fc_data_i,
  input  logic [2:0]  updfc_req_i,
  input  logic        ack_req_i,
  input  logic        ack_nak_i,
  input  logic [11:0] ack_seq_i,
  output logic        ack_done_o,
  output logic [2:0]  updfc_done_o,
  input  logic        tlp_req_i,
  input  logic        tlp_last_i,
  output logic        tlp_gnt_o,
  output logic        dllp_valid_o,
  output logic [31:0] dllp_o,
  output logic [1:0]  dl_state_o,
  output logic        dl_up_o,
  output logic [15:0] stat_ack_o,
  output logic [15:0] stat_nak_o,
  output logic [15:0] stat_updfc_o
);

  typedef enum logic [1:0] {
    S_INACTIVE = 2'd0,
    S_INITFC1  = 2'd1,
    S_INITFC2  = 2'd2,
    S_ACTIVE   = 2'd3
  } dl_state_t;

  // Cadence counter: 0..2 send the P/NP/Cpl triple, 3..INITFC_GAP+2 are idle.
  localparam int                CAD_W    = $clog2(INITFC_GAP + 3);
  localparam logic [CAD_W-1:0]  CAD_ZERO = CAD_W'(0);
  localparam logic [CAD_W-1:0]  CAD_ONE  = CAD_W'(1);
  localparam logic [CAD_W-1:0]  CAD_CPL  = CAD_W'(2);
  localparam logic [CAD_W-1:0]  CAD_LAST = CAD_W'(INITFC_GAP + 2);
  localparam int                TMR_W    = $clog2(UPDFC_PERIOD);
  localparam logic [TMR_W-1:0]  TMR_ZERO = TMR_W'(0);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(UPDFC_PERIOD - 1);
  localparam int                BST_W    = $clog2(MAX_DLLP_BURST + 1);
  localparam logic [BST_W-1:0]  BST_ZERO = BST_W'(0);
  localparam logic [BST_W-1:0]  BST_ONE  = BST_W'(1);
  localparam logic [BST_W-1:0]  BST_MAX  = BST_W'(MAX_DLLP_BURST);

  // Flow-control DLLP body; idx 0/1/2 = P/NP/Cpl, type nibble steps by 0x10.
  function automatic logic [31:0] fc_dllp(input logic [7:0] base, input logic [1:0] idx,
                                          input logic [23:0] hdr, input logic [35:0] data);
    logic [7:0]  t;
    logic [7:0]  h;
    logic [11:0] d;
    case (idx)
      2'd0:    begin t = base;         h = hdr[7:0];   d = data[11:0];  end
      2'd1:    begin t = base | 8'h10; h = hdr[15:8];  d = data[23:12]; end
      2'd2:    begin t = base | 8'h20; h = hdr[23:16]; d = data[35:24]; end
      default: begin t = base;         h = 8'h00;      d = 12'h000;     end
    endcase
    return {t, 2'b00, h, 2'b00, d};
  endfunction

  // Ack (0x00) / Nak (0x10) DLLP body.
  function automatic logic [31:0] ack_dllp(input logic nak, input logic [11:0] seq);
    return {(nak ? 8'h10 : 8'h00), 12'h000, seq};
  endfunction

  dl_state_t        state_r, state_s;
  logic [CAD_W-1:0] cad_r, cad_s;
  logic [2:0]       fl1_r, fl1_s;
  logic             fi2_r, fi2_s;
  logic [2:0]       pend_r, pend_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic [BST_W-1:0] burst_r, burst_s;
  logic             tlp_open_r, tlp_open_s;
  logic             dllp_valid_r, dllp_valid_s;
  logic [31:0]      dllp_r, dllp_s;
  logic             tlp_gnt_r, tlp_gnt_s;
  logic             ack_done_r, ack_done_s;
  logic [2:0]       updfc_done_r, updfc_done_s;
  logic             ack_want_s;
  logic [2:0]       upd_want_s;
  logic [2:0]       upd_served_s;
  logic [1:0]       upd_idx_s;
  logic [BST_W-1:0] burst_inc_s;

  // A request whose done pulse is on the bus right now is the one just served;
  // the requester only drops its level at the next edge, so mask it here.
  assign ack_want_s  = ack_req_i & ~ack_done_r;
  assign upd_want_s  = (updfc_req_i & ~updfc_done_r) | pend_r;
  assign burst_inc_s = (tlp_req_i == 1'b0) ? BST_ZERO :
                       (burst_r < BST_MAX) ? burst_r + BST_ONE : burst_r;

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_s      = state_r;
    cad_s        = cad_r;
    fl1_s        = fl1_r | rx_fc1_i;
    fi2_s        = fi2_r | rx_fc2_i;
    pend_s       = pend_r;
    timer_s      = timer_r;
    burst_s      = burst_r;
    tlp_open_s   = tlp_open_r;
    dllp_valid_s = 1'b0;
    dllp_s       = 32'h0000_0000;
    tlp_gnt_s    = 1'b0;
    ack_done_s   = 1'b0;
    updfc_done_s = 3'b000;
    upd_served_s = 3'b000;
    upd_idx_s    = 2'd0;
    if (!link_up_i) begin
      // Link loss: drop everything, including an open TLP.
      state_s    = S_INACTIVE;
      cad_s      = CAD_ZERO;
      fl1_s      = 3'b000;
      fi2_s      = 1'b0;
      pend_s     = 3'b000;
      timer_s    = TMR_ZERO;
      burst_s    = BST_ZERO;
      tlp_open_s = 1'b0;
    end else begin
      case (state_r)
        S_INACTIVE: begin
          state_s = S_INITFC1;
          cad_s   = CAD_ZERO;
        end
        S_INITFC1, S_INITFC2: begin
          if (cad_r <= CAD_CPL) begin
            dllp_valid_s = 1'b1;
            dllp_s = fc_dllp((state_r == S_INITFC1) ? 8'h40 : 8'hC0, cad_r[1:0], fc_hdr_i, fc_data_i);
          end else begin
            dllp_valid_s = 1'b0;
          end
          if (cad_r == CAD_LAST) begin
            cad_s = CAD_ZERO;
          end else begin
            cad_s = cad_r + CAD_ONE;
          end
          // Leave only once the Cpl DLLP of the triple is going out.
          if (cad_r == CAD_CPL) begin
            if ((state_r == S_INITFC1) && (&fl1_s)) begin
              state_s = S_INITFC2;
              cad_s   = CAD_ZERO;
            end else if ((state_r == S_INITFC2) && fi2_s) begin
              state_s = S_ACTIVE;
              cad_s   = CAD_ZERO;
            end else begin
              state_s = state_r;
            end
          end else begin
            state_s = state_r;
          end
        end
        S_ACTIVE: begin
          if (timer_r == TMR_LAST) begin
            timer_s = TMR_ZERO;
          end else begin
            timer_s = timer_r + TMR_ONE;
          end
          if (upd_want_s[0]) begin
            upd_idx_s = 2'd0;
          end else if (upd_want_s[1]) begin
            upd_idx_s = 2'd1;
          end else begin
            upd_idx_s = 2'd2;
          end
          if (tlp_open_r) begin
            // Non-preemptive TLP: a low tlp_req_i is an idle slot it still owns.
            if (tlp_req_i) begin
              tlp_gnt_s  = 1'b1;
              tlp_open_s = ~tlp_last_i;
            end else begin
              tlp_gnt_s  = 1'b0;
            end
            burst_s = BST_ZERO;
          end else if (tlp_req_i && (burst_r >= BST_MAX)) begin
            tlp_gnt_s  = 1'b1;
            tlp_open_s = ~tlp_last_i;
            burst_s    = BST_ZERO;
          end else if (ack_want_s) begin
            dllp_valid_s = 1'b1;
            dllp_s       = ack_dllp(ack_nak_i, ack_seq_i);
            ack_done_s   = 1'b1;
            burst_s      = burst_inc_s;
          end else if (|upd_want_s) begin
            dllp_valid_s = 1'b1;
            dllp_s       = fc_dllp(8'h80, upd_idx_s, fc_hdr_i, fc_data_i);
            upd_served_s = 3'b001 << upd_idx_s;
            updfc_done_s = upd_served_s;
            burst_s      = burst_inc_s;
          end else if (tlp_req_i) begin
            tlp_gnt_s  = 1'b1;
            tlp_open_s = ~tlp_last_i;
            burst_s    = BST_ZERO;
          end else begin
            burst_s = BST_ZERO;
          end
          // A new timer round wins over clearing the type just served.
          pend_s = (pend_r & ~upd_served_s) | ((timer_r == TMR_LAST) ? 3'b111 : 3'b000);
        end
        default: begin
          state_s = S_INACTIVE;
        end
      endcase
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      state_r      <= S_INACTIVE;
      cad_r        <= CAD_ZERO;
      fl1_r        <= 3'b000;
      fi2_r        <= 1'b0;
      pend_r       <= 3'b000;
      timer_r      <= TMR_ZERO;
      burst_r      <= BST_ZERO;
      tlp_open_r   <= 1'b0;
      dllp_valid_r <= 1'b0;
      dllp_r       <= 32'h0000_0000;
      tlp_gnt_r    <= 1'b0;
      ack_done_r   <= 1'b0;
      updfc_done_r <= 3'b000;
    end else begin
      state_r      <= state_s;
      cad_r        <= cad_s;
      fl1_r        <= fl1_s;
      fi2_r        <= fi2_s;
      pend_r       <= pend_s;
      timer_r      <= timer_s;
      burst_r      <= burst_s;
      tlp_open_r   <= tlp_open_s;
      dllp_valid_r <= dllp_valid_s;
      dllp_r       <= dllp_s;
      tlp_gnt_r    <= tlp_gnt_s;
      ack_done_r   <= ack_done_s;
      updfc_done_r <= updfc_done_s;
    end
  end

  assign dllp_valid_o = dllp_valid_r;
  assign dllp_o       = dllp_r;
  assign tlp_gnt_o    = tlp_gnt_r;
  assign ack_done_o   = ack_done_r;
  assign updfc_done_o = updfc_done_r;
  assign dl_state_o   = state_r;
  assign dl_up_o      = (state_r == S_ACTIVE);

`ifdef DLLP_TX_STATS_EN
  logic [15:0] stat_ack_r, stat_nak_r, stat_upd_r;
  logic        sent_ack_s, sent_nak_s, sent_upd_s;

  assign sent_ack_s = ack_done_s & ~ack_nak_i;
  assign sent_nak_s = ack_done_s & ack_nak_i;
  assign sent_upd_s = |updfc_done_s;

  // Saturating DLLP counters, restarted whenever the link falls to Inactive.
  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      stat_ack_r <= 16'h0000;
      stat_nak_r <= 16'h0000;
      stat_upd_r <= 16'h0000;
    end else if (state_s == S_INACTIVE) begin
      stat_ack_r <= 16'h0000;
      stat_nak_r <= 16'h0000;
      stat_upd_r <= 16'h0000;
    end else begin
      if (sent_ack_s && (stat_ack_r != 16'hFFFF)) stat_ack_r <= stat_ack_r + 16'd1;
      if (sent_nak_s && (stat_nak_r != 16'hFFFF)) stat_nak_r <= stat_nak_r + 16'd1;
      if (sent_upd_s && (stat_upd_r != 16'hFFFF)) stat_upd_r <= stat_upd_r + 16'd1;
    end
  end

  assign stat_ack_o   = stat_ack_r;
  assign stat_nak_o   = stat_nak_r;
  assign stat_updfc_o = stat_upd_r;
`else
  assign stat_ack_o   = 16'h0000;
  assign stat_nak_o   = 16'h0000;
  assign stat_updfc_o = 16'h0000;
`endif

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Scoreboard bench for dllp_tx_scheduler (UPDFC_PERIOD=16). Stimulus pushes
// the expected slot contents (kind, DLLP body, done pulses, idle slots since
// the previous presentation) into a queue; a monitor pops and compares every
// cycle the DUT presents a DLLP or a TLP grant.
module tb_dllp_tx_scheduler;

  logic        pclk;
  logic        rst_n;
  logic        link_up_i;
  logic [2:0]  rx_fc1_i;
  logic        rx_fc2_i;
  logic [23:0] fc_hdr_i;
  logic [35:0] fc_data_i;
  logic [2:0]  updfc_req_i;
  logic        ack_req_i;
  logic        ack_nak_i;
  logic [11:0] ack_seq_i;
  logic        ack_done_o;
  logic [2:0]  updfc_done_o;
  logic        tlp_req_i;
  logic        tlp_last_i;
  logic        tlp_gnt_o;
  logic        dllp_valid_o;
  logic [31:0] dllp_o;
  logic [1:0]  dl_state_o;
  logic        dl_up_o;
  logic [15:0] stat_ack_o;
  logic [15:0] stat_nak_o;
  logic [15:0] stat_updfc_o;

  dllp_tx_scheduler #(
    .UPDFC_PERIOD   (16),
    .INITFC_GAP     (8),
    .MAX_DLLP_BURST (4)
  ) dut (
    .pclk         (pclk),
    .rst_n        (rst_n),
    .link_up_i    (link_up_i),
    .rx_fc1_i     (rx_fc1_i),
    .rx_fc2_i     (rx_fc2_i),
    .fc_hdr_i     (fc_hdr_i),
    .fc_data_i    (fc_data_i),
    .updfc_req_i  (updfc_req_i),
    .ack_req_i    (ack_req_i),
    .ack_nak_i    (ack_nak_i),
    .ack_seq_i    (ack_seq_i),
    .ack_done_o   (ack_done_o),
    .updfc_done_o (updfc_done_o),
    .tlp_req_i    (tlp_req_i),
    .tlp_last_i   (tlp_last_i),
    .tlp_gnt_o    (tlp_gnt_o),
    .dllp_valid_o (dllp_valid_o),
    .dllp_o       (dllp_o),
    .dl_state_o   (dl_state_o),
    .dl_up_o      (dl_up_o),
    .stat_ack_o   (stat_ack_o),
    .stat_nak_o   (stat_nak_o),
    .stat_updfc_o (stat_updfc_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    string       name;
    logic [1:0]  kind;   // {dllp_valid, tlp_gnt}
    logic [31:0] data;
    logic        ack;
    logic [2:0]  upd;
    int          gap;    // idle slots before this one, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Credits: P hdr 0x11 data 0x222, NP 0x22/0x444, Cpl 0x33/0x555.
  localparam logic [31:0] FC1_P  = 32'h4004_4222;
  localparam logic [31:0] FC1_NP = 32'h5008_8444;
  localparam logic [31:0] FC1_C  = 32'h600C_C555;
  localparam logic [31:0] FC2_P  = 32'hC004_4222;
  localparam logic [31:0] FC2_NP = 32'hD008_8444;
  localparam logic [31:0] FC2_C  = 32'hE00C_C555;
  localparam logic [31:0] UPD_P  = 32'h8004_4222;
  localparam logic [31:0] UPD_NP = 32'h9008_8444;
  localparam logic [31:0] UPD_C  = 32'hA00C_C555;

  task automatic push_dllp(input string name, input logic [31:0] d, input logic a,
                           input logic [2:0] u, input int gap);
    exp_t e;
    e.name = name; e.kind = 2'b10; e.data = d; e.ack = a; e.upd = u; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_tlp(input string name, input int gap);
    exp_t e;
    e.name = name; e.kind = 2'b01; e.data = 32'h0; e.ack = 1'b0; e.upd = 3'b000; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_upd_round(input string name, input int gap);
    push_dllp({name, "_p"},   UPD_P,  1'b0, 3'b001, gap);
    push_dllp({name, "_np"},  UPD_NP, 1'b0, 3'b010, 0);
    push_dllp({name, "_cpl"}, UPD_C,  1'b0, 3'b100, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; link_up_i = 1'b0; rx_fc1_i = 3'b000; rx_fc2_i = 1'b0;
    fc_hdr_i = 24'h33_22_11; fc_data_i = 36'h555_444_222;
    updfc_req_i = 3'b000; ack_req_i = 1'b0; ack_nak_i = 1'b0; ack_seq_i = 12'h000;
    tlp_req_i = 1'b0; tlp_last_i = 1'b0;

    fork
      begin : monitor
        exp_t        e;
        int          idle_cnt;
        logic        ok;
        logic [31:0] act_data;
        idle_cnt = 0;
        forever begin
          @(negedge pclk);
          if (dllp_valid_o || tlp_gnt_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              $display("FAIL unexpected_slot: got valid=%0b gnt=%0b dllp=%h, required no output",
                       dllp_valid_o, tlp_gnt_o, dllp_o);
            end else begin
              e = exp_q.pop_front();
              act_data = dllp_valid_o ? dllp_o : 32'h0;
              ok = ({dllp_valid_o, tlp_gnt_o} == e.kind) && (act_data == e.data) &&
                   (ack_done_o == e.ack) && (updfc_done_o == e.upd) &&
                   ((e.gap < 0) || (idle_cnt == e.gap));
              if (ok) n_pass++;
              else $display("FAIL %s: got kind=%b dllp=%h ack_done=%b updfc_done=%b gap=%0d, required kind=%b dllp=%h ack_done=%b updfc_done=%b gap=%0d",
                            e.name, {dllp_valid_o, tlp_gnt_o}, act_data, ack_done_o, updfc_done_o,
                            idle_cnt, e.kind, e.data, e.ack, e.upd, e.gap);
            end
            idle_cnt = 0;
          end else begin
            idle_cnt++;
          end
        end
      end
    join_none

    // Reset state.
    tick(3);
    chk("rst_outputs", 32'({dllp_valid_o, tlp_gnt_o, ack_done_o, updfc_done_o, dl_up_o}), 32'h0);
    chk("rst_dllp", dllp_o, 32'h0);
    chk("rst_state", 32'(dl_state_o), 32'd0);
    chk("rst_stats", 32'(stat_ack_o | stat_nak_o | stat_updfc_o), 32'h0);
    rst_n = 1'b0;
    tick(2);
    chk("idle_inactive", 32'(dl_state_o), 32'd0);

    // InitFC1: four triples separated by 8 idles, then InitFC2 once FL1/FI2 set.
    link_up_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_dllp("fc1_p",   FC1_P,  1'b0, 3'b000, (k == 0) ? -1 : 8);
      push_dllp("fc1_np",  FC1_NP, 1'b0, 3'b000, 0);
      push_dllp("fc1_cpl", FC1_C,  1'b0, 3'b000, 0);
    end
    push_dllp("fc2_p",   FC2_P,  1'b0, 3'b000, 0);
    push_dllp("fc2_np",  FC2_NP, 1'b0, 3'b000, 0);
    push_dllp("fc2_cpl", FC2_C,  1'b0, 3'b000, 0);
    tick(20);
    chk("stay_initfc1", 32'(dl_state_o), 32'd1);
    tick(15);
    rx_fc1_i = 3'b111;             // during the NP slot of the 4th triple
    tick(1);
    rx_fc1_i = 3'b000;
    chk("initfc1_mid_triple", 32'(dl_state_o), 32'd1);
    tick(2);
    rx_fc2_i = 1'b1;
    tick(1);
    rx_fc2_i = 1'b0;
    chk("initfc2_state", 32'(dl_state_o), 32'd2);
    tick(1);
    chk("active_state", 32'({dl_up_o, dl_state_o}), 32'h7);

    // Priority: Nak, then UpdateFC P, then the single-beat TLP.
    ack_req_i = 1'b1; ack_nak_i = 1'b1; ack_seq_i = 12'h123;
    updfc_req_i = 3'b001; tlp_req_i = 1'b1; tlp_last_i = 1'b1;
    push_dllp("prio_nak", 32'h1000_0123, 1'b1, 3'b000, 0);
    push_dllp("prio_updfc_p", UPD_P, 1'b0, 3'b001, 0);
    push_tlp("prio_tlp", 0);
    tick(1); ack_req_i = 1'b0;
    tick(1); updfc_req_i = 3'b000;
    tick(1); tlp_req_i = 1'b0; tlp_last_i = 1'b0;

    // 5-beat TLP with an Ack raised on beat 2: the Ack waits for the last beat.
    tick(2);
    tlp_req_i = 1'b1;
    push_tlp("tlp5_b1", 2);
    for (int b = 2; b <= 5; b++) push_tlp("tlp5_bn", 0);
    push_dllp("ack_after_tlp", 32'h0000_0456, 1'b1, 3'b000, 0);
    tick(1); ack_req_i = 1'b1; ack_nak_i = 1'b0; ack_seq_i = 12'h456;
    tick(3); tlp_last_i = 1'b1;
    tick(1); tlp_req_i = 1'b0; tlp_last_i = 1'b0;
    tick(1); ack_req_i = 1'b0;

    // Idle Active: timer-driven UpdateFC triple every 16 cycles.
    push_upd_round("timer1", 5);
    push_upd_round("timer2", 13);
    tick(26);

    // Starvation guard: continuous Ack/UpdateFC requests, TLP forced after 4 DLLPs.
    ack_req_i = 1'b1; ack_nak_i = 1'b0; ack_seq_i = 12'h0AA;
    updfc_req_i = 3'b111; tlp_req_i = 1'b1; tlp_last_i = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_dllp("starve_ack", 32'h0000_00AA, 1'b1, 3'b000, (r == 0) ? 2 : 0);
      push_dllp("starve_upd", UPD_P, 1'b0, 3'b001, 0);
      push_dllp("starve_ack", 32'h0000_00AA, 1'b1, 3'b000, 0);
      push_dllp("starve_upd", UPD_P, 1'b0, 3'b001, 0);
      push_tlp("starve_tlp", 0);
    end
    tick(10);
    ack_req_i = 1'b0; updfc_req_i = 3'b000; tlp_req_i = 1'b0; tlp_last_i = 1'b0;
    push_upd_round("timer3", 1);
    tick(6);
`ifdef DLLP_TX_STATS_EN
    chk("stat_ack", 32'(stat_ack_o), 32'd5);
    chk("stat_nak", 32'(stat_nak_o), 32'd1);
    chk("stat_updfc", 32'(stat_updfc_o), 32'd14);
`endif

    // Link drop in the middle of a TLP; Ack held while down is not serviced.
    tlp_req_i = 1'b1;
    push_tlp("drop_tlp_b1", 2);
    push_tlp("drop_tlp_b2", 0);
    tick(2);
    link_up_i = 1'b0;
    ack_req_i = 1'b1;
    tick(1);
    chk("drop_gnt", 32'(tlp_gnt_o), 32'd0);
    chk("drop_state", 32'({dl_up_o, dl_state_o}), 32'd0);
    chk("drop_stats", 32'(stat_ack_o | stat_nak_o | stat_updfc_o), 32'h0);
    tick(5);
    chk("held_ack_no_done", 32'({ack_done_o, dllp_valid_o}), 32'd0);
    ack_req_i = 1'b0; tlp_req_i = 1'b0;

    for (int w = 0; (w < 50) && (exp_q.size() != 0); w++) tick(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
